// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with rename-tag tracking.
//
// Each register holds a value, a busy bit and the ROB tag of its pending producer.
// The dispatcher reads READ_PORTS source operands combinationally and claims a
// destination tag. The ROB retires values at the head and can flush all pending
// tags on a misprediction. x0 is hardwired to zero and is never busy.
//
// Ports:
//   clk_in           clock
//   rst_in           synchronous active-high reset (wins over everything)
//   rdy_in           global enable; state frozen when low
//   rd_addr_in       source register index per read port
//   rd_busy_out      per port: operand still pending in the ROB
//   rd_value_out     per port: register value (valid when not busy)
//   rd_tag_out       per port: producing ROB tag (valid when busy)
//   disp_en_in       dispatcher claims disp_rd_in with disp_tag_in
//   disp_rd_in       destination register being renamed
//   disp_tag_in      ROB entry allocated to the destination
//   commit_en_in     ROB retires a register-writing instruction
//   commit_rd_in     retired destination register
//   commit_value_in  retired value
//   commit_tag_in    retired ROB tag
//   flush_in         misprediction flush: drop every pending tag
//   busy_count_out   registered count of busy registers
module regfile_rename #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic [READ_PORTS*REG_WIDTH-1:0] rd_addr_in,
    output logic [READ_PORTS-1:0]           rd_busy_out,
    output logic [READ_PORTS*XLEN-1:0]      rd_value_out,
    output logic [READ_PORTS*ROB_WIDTH-1:0] rd_tag_out,
    input  logic                            disp_en_in,
    input  logic [REG_WIDTH-1:0]            disp_rd_in,
    input  logic [ROB_WIDTH-1:0]            disp_tag_in,
    input  logic                            commit_en_in,
    input  logic [REG_WIDTH-1:0]            commit_rd_in,
    input  logic [XLEN-1:0]                 commit_value_in,
    input  logic [ROB_WIDTH-1:0]            commit_tag_in,
    input  logic                            flush_in,
    output logic [REG_WIDTH:0]              busy_count_out
);

    logic [XLEN-1:0]      value_q [REG_COUNT];
    logic [XLEN-1:0]      value_d [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_d   [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [REG_WIDTH:0]   busy_count_q, busy_count_d;

    logic commit_wr;     // commit writes a value this cycle
    logic commit_match;  // commit retires the register's current producer
    logic disp_wr;       // dispatch renames a register this cycle

    assign commit_wr    = rdy_in && commit_en_in && (commit_rd_in != '0);
    assign commit_match = commit_wr && busy_q[commit_rd_in] &&
                          (tag_q[commit_rd_in] == commit_tag_in);
    assign disp_wr      = rdy_in && disp_en_in && !flush_in && (disp_rd_in != '0);

    // Source lookup. A same-cycle commit is bypassed in; a same-cycle dispatch is
    // deliberately not, so the dispatching instruction sees its own sources as they
    // were before it renamed its destination.
    logic [REG_WIDTH-1:0] rd_addr;

    always_comb begin
        rd_busy_out  = '0;
        rd_value_out = '0;
        rd_tag_out   = '0;
        rd_addr      = '0;
        for (int k = 0; k < READ_PORTS; k++) begin
            rd_addr = rd_addr_in[k*REG_WIDTH +: REG_WIDTH];
            if (rd_addr != '0) begin
                if (commit_wr && (commit_rd_in == rd_addr)) begin
                    rd_value_out[k*XLEN +: XLEN] = commit_value_in;
                    // A mismatching tag means a younger writer is still pending.
                    rd_busy_out[k] = busy_q[rd_addr] && !commit_match;
                    rd_tag_out[k*ROB_WIDTH +: ROB_WIDTH] =
                        commit_match ? '0 : tag_q[rd_addr];
                end else begin
                    rd_value_out[k*XLEN +: XLEN]         = value_q[rd_addr];
                    rd_busy_out[k]                       = busy_q[rd_addr];
                    rd_tag_out[k*ROB_WIDTH +: ROB_WIDTH] = tag_q[rd_addr];
                end
            end
        end
    end

    // Next state: commit, then flush, then dispatch; later steps override earlier.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;

        if (commit_wr) begin
            value_d[commit_rd_in] = commit_value_in;
            if (commit_match) begin
                busy_d[commit_rd_in] = 1'b0;
                tag_d[commit_rd_in]  = '0;
            end
        end

        if (rdy_in && flush_in) begin
            busy_d = '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                tag_d[i] = '0;
            end
        end

        if (disp_wr) begin
            busy_d[disp_rd_in] = 1'b1;
            tag_d[disp_rd_in]  = disp_tag_in;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            busy_count_d = busy_count_d + {{REG_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    // When rdy_in is low every *_d equals its *_q, so the state holds.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            value_q      <= value_d;
            tag_q        <= tag_d;
        end
    end

    assign busy_count_out = busy_count_q;

endmodule

// File: tb/tb_regfile_rename.sv
module tb_regfile_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [9:0]  rd_addr_in;
    logic [1:0]  rd_busy_out;
    logic [63:0] rd_value_out;
    logic [7:0]  rd_tag_out;
    logic        disp_en_in;
    logic [4:0]  disp_rd_in;
    logic [3:0]  disp_tag_in;
    logic        commit_en_in;
    logic [4:0]  commit_rd_in;
    logic [31:0] commit_value_in;
    logic [3:0]  commit_tag_in;
    logic        flush_in;
    logic [5:0]  busy_count_out;

    regfile_rename dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .rd_addr_in      (rd_addr_in),
        .rd_busy_out     (rd_busy_out),
        .rd_value_out    (rd_value_out),
        .rd_tag_out      (rd_tag_out),
        .disp_en_in      (disp_en_in),
        .disp_rd_in      (disp_rd_in),
        .disp_tag_in     (disp_tag_in),
        .commit_en_in    (commit_en_in),
        .commit_rd_in    (commit_rd_in),
        .commit_value_in (commit_value_in),
        .commit_tag_in   (commit_tag_in),
        .flush_in        (flush_in),
        .busy_count_out  (busy_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst, rdy, de;
        logic [4:0]  dr;
        logic [3:0]  dt;
        logic        ce;
        logic [4:0]  cr;
        logic [31:0] cv;
        logic [3:0]  ct;
        logic        fl;
        logic [4:0]  a0;
        logic        b0;
        logic [31:0] v0;
        logic [3:0]  t0;
        logic [4:0]  a1;
        logic        b1;
        logic [31:0] v1;
        logic [3:0]  t1;
        logic [5:0]  cnt;   // busy_count_out expected after this cycle's edge
    } vec_t;

    vec_t tbl [$];
    logic [5:0] cnt_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rdy, logic de, logic [4:0] dr, logic [3:0] dt,
                                logic ce, logic [4:0] cr, logic [31:0] cv, logic [3:0] ct,
                                logic fl,
                                logic [4:0] a0, logic b0, logic [31:0] v0, logic [3:0] t0,
                                logic [4:0] a1, logic b1, logic [31:0] v1, logic [3:0] t1,
                                logic [5:0] cnt);
        vec_t r;
        r.rst = 1'b0; r.rdy = rdy; r.de = de; r.dr = dr; r.dt = dt;
        r.ce = ce; r.cr = cr; r.cv = cv; r.ct = ct; r.fl = fl;
        r.a0 = a0; r.b0 = b0; r.v0 = v0; r.t0 = t0;
        r.a1 = a1; r.b1 = b1; r.v1 = v1; r.t1 = t1; r.cnt = cnt;
        return r;
    endfunction

    // Drive one cycle of stimulus at the falling edge, check the combinational reads
    // before the rising edge and queue the expected post-edge busy count.
    task automatic run_vec(input vec_t x, input string tag);
        @(negedge clk_in);
        rst_in          = x.rst;
        rdy_in          = x.rdy;
        disp_en_in      = x.de;
        disp_rd_in      = x.dr;
        disp_tag_in     = x.dt;
        commit_en_in    = x.ce;
        commit_rd_in    = x.cr;
        commit_value_in = x.cv;
        commit_tag_in   = x.ct;
        flush_in        = x.fl;
        rd_addr_in      = {x.a1, x.a0};
        cnt_q.push_back(x.cnt);
        #1;
        if (!x.rst) begin
            check({tag, " p0 busy"},  {31'd0, rd_busy_out[0]}, {31'd0, x.b0});
            check({tag, " p0 value"}, rd_value_out[31:0],      x.v0);
            check({tag, " p0 tag"},   {28'd0, rd_tag_out[3:0]}, {28'd0, x.t0});
            check({tag, " p1 busy"},  {31'd0, rd_busy_out[1]}, {31'd0, x.b1});
            check({tag, " p1 value"}, rd_value_out[63:32],     x.v1);
            check({tag, " p1 tag"},   {28'd0, rd_tag_out[7:4]}, {28'd0, x.t1});
        end
    endtask

    // Busy-count scoreboard: one expected value per driven cycle.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk_in);
            #1;
            if (cnt_q.size() > 0) begin
                e = cnt_q.pop_front();
                check("busy_count", {26'd0, busy_count_out}, {26'd0, e});
            end
        end
    end

    initial begin
        vec_t r;
        rst_in = 1'b1; rdy_in = 1'b1; disp_en_in = 1'b0; disp_rd_in = '0; disp_tag_in = '0;
        commit_en_in = 1'b0; commit_rd_in = '0; commit_value_in = '0; commit_tag_in = '0;
        flush_in = 1'b0; rd_addr_in = '0;
        repeat (2) @(posedge clk_in);

        //           rdy   de    dr     dt    ce    cr     cv            ct    fl
        //           a0 b0 v0 t0 | a1 b1 v1 t1 | cnt
        // Post-reset reads.
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd1, 1'b0, 32'h0, 4'd0, 5'd31, 1'b0, 32'h0, 4'd0, 6'd0));
        // Dispatch x5/3; sources see pre-dispatch state.
        tbl.push_back(mk(1'b1, 1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd5, 1'b0, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd5, 1'b1, 32'h0, 4'd3, 5'd31, 1'b0, 32'h0, 4'd0, 6'd1));
        // Matching commit: bypassed on both ports.
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0,
                         5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 6'd0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 5'd1, 1'b0, 32'h0, 4'd0, 6'd0));
        // x7: two writers, the older one commits.
        tbl.push_back(mk(1'b1, 1'b1, 5'd7, 4'd2, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd7, 1'b0, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        tbl.push_back(mk(1'b1, 1'b1, 5'd7, 4'd6, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd7, 1'b1, 32'h0, 4'd2, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 32'h11, 4'd2, 1'b0,
                         5'd7, 1'b1, 32'h11, 4'd6, 5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 6'd1));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd7, 1'b1, 32'h11, 4'd6, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        // x9: commit tag 4 and dispatch tag 5 in the same cycle.
        tbl.push_back(mk(1'b1, 1'b1, 5'd9, 4'd4, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd9, 1'b0, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd2));
        tbl.push_back(mk(1'b1, 1'b1, 5'd9, 4'd5, 1'b1, 5'd9, 32'hCAFE0009, 4'd4, 1'b0,
                         5'd9, 1'b0, 32'hCAFE0009, 4'd0, 5'd9, 1'b0, 32'hCAFE0009, 4'd0, 6'd2));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd9, 1'b1, 32'hCAFE0009, 4'd5, 5'd7, 1'b1, 32'h11, 4'd6, 6'd2));
        // Busy x3, x4, x10, then flush with dispatch x12 and commit x3.
        tbl.push_back(mk(1'b1, 1'b1, 5'd3, 4'd7, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd3, 1'b0, 32'h0, 4'd0, 5'd4, 1'b0, 32'h0, 4'd0, 6'd3));
        tbl.push_back(mk(1'b1, 1'b1, 5'd4, 4'd8, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd3, 1'b1, 32'h0, 4'd7, 5'd4, 1'b0, 32'h0, 4'd0, 6'd4));
        tbl.push_back(mk(1'b1, 1'b1, 5'd10, 4'd9, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd4, 1'b1, 32'h0, 4'd8, 5'd10, 1'b0, 32'h0, 4'd0, 6'd5));
        tbl.push_back(mk(1'b1, 1'b1, 5'd12, 4'd1, 1'b1, 5'd3, 32'h55, 4'd7, 1'b1,
                         5'd3, 1'b0, 32'h55, 4'd0, 5'd12, 1'b0, 32'h0, 4'd0, 6'd0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd12, 1'b0, 32'h0, 4'd0, 5'd3, 1'b0, 32'h55, 4'd0, 6'd0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd9, 1'b0, 32'hCAFE0009, 4'd0, 5'd10, 1'b0, 32'h0, 4'd0, 6'd0));
        // x0 ignores dispatch and commit.
        tbl.push_back(mk(1'b1, 1'b1, 5'd0, 4'd3, 1'b1, 5'd0, 32'hFFFFFFFF, 4'd0, 1'b0,
                         5'd0, 1'b0, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd0, 1'b0, 32'h0, 4'd0, 5'd8, 1'b0, 32'h0, 4'd0, 6'd0));
        // rdy_in low: dispatch and commit dropped, no commit bypass.
        tbl.push_back(mk(1'b0, 1'b1, 5'd8, 4'd2, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd8, 1'b0, 32'h0, 4'd0, 5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 6'd0));
        tbl.push_back(mk(1'b0, 1'b1, 5'd8, 4'd2, 1'b1, 5'd5, 32'h77, 4'd0, 1'b0,
                         5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 5'd8, 1'b0, 32'h0, 4'd0, 6'd0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd8, 1'b0, 32'h0, 4'd0, 5'd5, 1'b0, 32'hDEADBEEF, 4'd0, 6'd0));
        // Tag 0 is a real tag.
        tbl.push_back(mk(1'b1, 1'b1, 5'd6, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd6, 1'b0, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd6, 1'b1, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b1, 5'd6, 32'h66, 4'd0, 1'b0,
                         5'd6, 1'b0, 32'h66, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd0));
        // Flush and commit ignored while rdy_in is low.
        tbl.push_back(mk(1'b1, 1'b1, 5'd2, 4'd10, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                         5'd2, 1'b0, 32'h0, 4'd0, 5'd6, 1'b0, 32'h66, 4'd0, 6'd1));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b1,
                         5'd2, 1'b1, 32'h0, 4'd10, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));
        tbl.push_back(mk(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd2, 32'h22, 4'd10, 1'b0,
                         5'd2, 1'b1, 32'h0, 4'd10, 5'd0, 1'b0, 32'h0, 4'd0, 6'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Reset mid-operation, with rdy_in low and a dispatch pending: reset wins.
        r = mk(1'b0, 1'b1, 5'd11, 4'd4, 1'b1, 5'd2, 32'h99, 4'd10, 1'b0,
               5'd0, 1'b0, 32'h0, 4'd0, 5'd0, 1'b0, 32'h0, 4'd0, 6'd0);
        r.rst = 1'b1;
        run_vec(r, "rst");
        run_vec(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                   5'd2, 1'b0, 32'h0, 4'd0, 5'd5, 1'b0, 32'h0, 4'd0, 6'd0), "post_rst_a");
        run_vec(mk(1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0,
                   5'd11, 1'b0, 32'h0, 4'd0, 5'd9, 1'b0, 32'h0, 4'd0, 6'd0), "post_rst_b");

        // Let the scoreboard drain, bounded.
        for (int w = 0; w < 10 && cnt_q.size() > 0; w++) @(negedge clk_in);
        if (cnt_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", cnt_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
- Parametrised architectural register file with rename-tag (busy/ROB-tag) tracking for the Tomasulo out-of-order core.
- Sits between dispatcher and reorder buffer.
- Dispatcher reads N source operands per cycle and claims a destination tag.
- ROB commits values at the head and broadcasts flush on misprediction.
- Successor to the fixed two-port regfile, adding:
  - configurable read-port count and widths,
  - hardwired x0,
  - same-cycle commit-to-read bypass,
  - defined dispatch/commit/flush priorities.

Parameters:
XLEN, 32, data width of each register
REG_COUNT, 32, number of architectural registers (power of 2)
REG_WIDTH, 5, log2(REG_COUNT)
ROB_WIDTH, 4, ROB tag width
READ_PORTS, 2, number of source-operand lookup ports (1..4)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; state frozen when low
rd_addr_in  input  READ_PORTS*REG_WIDTH  source register index per port (port k at bits [k*REG_WIDTH +: REG_WIDTH])
rd_busy_out  output  READ_PORTS  1 = operand pending in ROB
rd_value_out  output  READ_PORTS*XLEN  register value (valid when busy=0)
rd_tag_out  output  READ_PORTS*ROB_WIDTH  producing ROB tag (valid when busy=1)
disp_en_in  input  1  dispatcher claims destination this cycle
disp_rd_in  input  REG_WIDTH  destination register
disp_tag_in  input  ROB_WIDTH  ROB entry allocated to destination
commit_en_in  input  1  ROB retires a register-writing instruction
commit_rd_in  input  REG_WIDTH  retired destination
commit_value_in  input  XLEN  retired value
commit_tag_in  input  ROB_WIDTH  retired ROB tag
flush_in  input  1  misprediction flush from ROB
busy_count_out  output  REG_WIDTH+1  number of registers currently busy (registered)

Behaviour:
- State per register: value[XLEN], busy, tag[ROB_WIDTH].
- Reset (rst_in=1 at posedge): all values=0, busy=0, tag=0, busy_count_out=0. Reset has priority over rdy_in and every other input.
- Reset mid-operation: all pending tags are discarded. Reads in the following cycle return busy=0, value=0, tag=0.
- x0: reads always return busy=0, value=0, tag=0. Dispatch and commit to x0 are ignored and do not change busy_count_out.
- Reads: combinational, zero latency, independent per port. For port k at address r:
  - if commit_en_in && commit_rd_in==r && r!=0: value = commit_value_in.
  - if that commit also has busy[r] && tag[r]==commit_tag_in: busy=0, tag=0.
  - otherwise: stored value, busy and tag.
- Reads never see the same-cycle dispatch. Sources of the dispatching instruction observe pre-dispatch state.
- Reads are unaffected by flush_in and rdy_in, except that the commit bypass applies only when rdy_in=1.
- Sequential update at posedge, only when rdy_in=1. Steps are evaluated in this order:
  1. Commit (commit_en_in, rd!=0): value[rd] <= commit_value_in. If busy[rd] && tag[rd]==commit_tag_in, clear busy[rd] and set tag[rd] to 0. On tag mismatch (a younger writer is pending), the value is written and busy/tag are untouched.
  2. Flush (flush_in): all busy <= 0, all tags <= 0. Values are kept, including a same-cycle commit value. Dispatch is ignored in a flush cycle.
  3. Dispatch (disp_en_in && !flush_in && rd!=0): busy[rd] <= 1, tag[rd] <= disp_tag_in. This overrides a same-cycle commit clear of the same register.
- busy_count_out: registered population count of busy bits after the update. It is 0 after flush.
- rdy_in=0: no state change. Commit/dispatch inputs are dropped; the upstream units must hold them.
- Tag 0 is a legal ROB tag. The busy bit alone qualifies the tag.

Test Plan:
- Reset, then read ports at x1 and x31 -> busy=0, value=0, tag=0; busy_count_out=0.
- Dispatch x5 tag 3; next cycle read x5 -> busy=1, tag=3; commit x5 tag 3 value 0xDEADBEEF -> same-cycle read returns busy=0, value=0xDEADBEEF; next cycle stored busy=0, busy_count_out=0.
- Dispatch x7 tag 2, then x7 tag 6; commit x7 tag 2 value 0x11 -> read shows value 0x11, busy=1, tag=6.
- Same cycle: commit x9 tag 4 (matching) and dispatch x9 tag 5, with port 0 reading x9 -> port 0 sees busy=0 and the commit value; next cycle x9 busy=1, tag=5.
- Busy x3, x4, x10; flush with a simultaneous dispatch x12 tag 1 and commit x3 value 0x55 -> all busy=0, x12 not busy, x3 value=0x55, busy_count_out=0.
- Dispatch/commit to x0 value 0xFFFFFFFF -> x0 reads 0, not busy. Then hold rdy_in=0 while pulsing dispatch x8 -> x8 is unchanged.
